inverse_zigzag: RTL and testbench

Inverse zigzag reorder for the decode path. Accepts a stream of 64 quantised coefficients per 8x8 block in zigzag order and emits the same block in raster order (index = {y,x}), ready for the IDCT. Two 64-entry banks in ping-pong arrangement let writing of block N+1 overlap reading of block N. Valid/ready handshakes on both sides.

---
 rtl/inverse_zigzag.sv | 180 ++++++++++++++++++
 tb/tb_inverse_zigzag.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_zigzag.sv
// Inverse zigzag: 64 zigzag-ordered coefficients in, raster {y,x} order out, via two ping-pong banks.
// First word 2 cycles after a block completes; valid/ready both sides. INV_ZIGZAG_EOB_EN adds early-EOB zero fill.
module inverse_zigzag #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_eob,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [5:0]            out_addr,
  output logic                  out_last
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [128];
  logic [2:0]            x_q, x_d, y_q, y_d, x_nxt, y_nxt;
  logic                  wb_q, wb_d, rb_q, rb_d;
  logic [1:0]            full_q, full_d, set_full, clr_full;
  logic [0:0]            state_q, state_d;
  logic [5:0]            r_q, r_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [5:0]            out_addr_q, out_addr_d;
  logic                  accept, wr_en, at_end, rd_issue, rd_release, bank_free;
  logic [DATA_WIDTH-1:0] wr_dat;

  assign accept     = in_valid && in_ready;
  assign at_end     = (x_q == 3'd7) && (y_q == 3'd7);
  assign rd_issue   = (state_q == ST_READ) && (!out_valid_q || out_ready);
  assign rd_release = rd_issue && (r_q == 6'd63);
  // A bank issuing its last read may already take zigzag index 0, which lands on long-consumed raster 0.
  assign bank_free  = !full_q[wb_q] || (rd_release && (rb_q == wb_q));

`ifdef INV_ZIGZAG_EOB_EN
  logic fill_q, fill_d;
  assign in_ready = bank_free && !fill_q;
`else
  logic unused_eob;
  assign unused_eob = in_eob;
  assign in_ready   = bank_free;
`endif

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (!(x_q[0] ^ y_q[0])) begin
      if (x_q == 3'd7) begin
        y_nxt = y_q + 3'd1;
      end else if (y_q == 3'd0) begin
        x_nxt = x_q + 3'd1;
      end else begin
        x_nxt = x_q + 3'd1;
        y_nxt = y_q - 3'd1;
      end
    end else begin
      if (y_q == 3'd7) begin
        x_nxt = x_q + 3'd1;
      end else if (x_q == 3'd0) begin
        y_nxt = y_q + 3'd1;
      end else begin
        x_nxt = x_q - 3'd1;
        y_nxt = y_q + 3'd1;
      end
    end
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    wb_d     = wb_q;
    set_full = 2'b00;
    wr_en    = accept;
    wr_dat   = in_data;
`ifdef INV_ZIGZAG_EOB_EN
    fill_d = fill_q;
    if (fill_q) begin
      wr_en  = 1'b1;
      wr_dat = '0;
    end
`endif
    if (wr_en) begin
      if (at_end) begin
        x_d            = 3'd0;
        y_d            = 3'd0;
        wb_d           = !wb_q;
        set_full[wb_q] = 1'b1;
`ifdef INV_ZIGZAG_EOB_EN
        fill_d = 1'b0;
`endif
      end else begin
        x_d = x_nxt;
        y_d = y_nxt;
`ifdef INV_ZIGZAG_EOB_EN
        if (accept && in_eob) fill_d = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    rb_d        = rb_q;
    clr_full    = 2'b00;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (out_ready) out_valid_d = 1'b0;
        if (full_q[rb_q]) begin
          state_d = ST_READ;
          r_d     = 6'd0;
        end
      end
      default: begin
        if (rd_issue) begin
          out_data_d  = mem_q[{rb_q, r_q}];
          out_addr_d  = r_q;
          out_valid_d = 1'b1;
          r_d         = r_q + 6'd1;
          if (r_q == 6'd63) begin
            clr_full[rb_q] = 1'b1;
            rb_d           = !rb_q;
            // Chain straight into the other bank when it is already waiting, keeping 1 word/cycle.
            if (!full_q[!rb_q]) state_d = ST_IDLE;
          end
        end
      end
    endcase
    full_d = (full_q | set_full) & ~clr_full;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wb_q, y_q, x_q}] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= 3'd0;
      y_q         <= 3'd0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      full_q      <= 2'b00;
      state_q     <= ST_IDLE;
      r_q         <= 6'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= 6'd0;
`ifdef INV_ZIGZAG_EOB_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      state_q     <= state_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
`ifdef INV_ZIGZAG_EOB_EN
      fill_q      <= fill_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_valid_q && (out_addr_q == 6'd63);
endmodule

// File: tb/tb_inverse_zigzag.sv
// Directed bench for inverse_zigzag: raster-order table, back-to-back blocks, stalls, reset, optional EOB fill.
module tb_inverse_zigzag;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_eob = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [5:0]    out_addr;

  inverse_zigzag #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eob(in_eob),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [5:0]    a;
    logic          l;
  } rec_t;

  typedef struct {
    int addr;
    int exp_d;
    int exp_last;
  } vec_t;

  // JPEG zigzag scan: zz[k] = raster index of the k-th coefficient.
  int zz [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                  12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                  35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                  58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  int rz [64];

  int   n_chk = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  int   in_stall = 0;
  int   stab_err = 0;
  rec_t log_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [5:0]    prev_a = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_d || out_addr !== prev_a))
        stab_err <= stab_err + 1;
      prev_stall <= out_valid && !out_ready;
      prev_d     <= out_data;
      prev_a     <= out_addr;
      if (out_valid && out_ready) log_q.push_back('{out_data, out_addr, out_last});
      if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
      if (in_valid && !in_ready) in_stall <= in_stall + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic eob);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_eob   = eob;
    forever begin
      @(negedge clk);
      if (in_ready || t >= 3000) break;
      t++;
    end
    if (t >= 3000) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_wait: got no in_ready in %0d cycles, want acceptance", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_eob   = 1'b0;
  endtask

  task automatic send_words(input int n, input int mul, input int add);
    for (int j = 0; j < n; j++) push_word(DW'((j * mul + add) % 1024), 1'b0);
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    int t;
    t = 0;
    while (log_q.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(name, log_q.size(), n);
  endtask

  task automatic check_blocks(input string name, input int base, input int nblk,
                              input int mul, input int add);
    int derr, aerr, lerr;
    derr = 0; aerr = 0; lerr = 0;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) begin
        int idx;
        int j;
        logic [DW-1:0] ed;
        idx = base + b * 64 + i;
        j   = b * 64 + rz[i];
        ed  = DW'((j * mul + add) % 1024);
        if (idx >= log_q.size()) begin
          derr++; aerr++; lerr++;
        end else begin
          if (log_q[idx].d !== ed) derr++;
          if (log_q[idx].a !== 6'(i)) aerr++;
          if (log_q[idx].l !== (i == 63)) lerr++;
        end
      end
    end
    chk({name, "_data_errs"}, derr, 0);
    chk({name, "_addr_errs"}, aerr, 0);
    chk({name, "_last_errs"}, lerr, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_eob   = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1);
  end

  initial begin
    vec_t tv [12];
    int   base, a0, s0, t, lo, errs;
    logic [DW-1:0] ed;

    tv[0]  = '{0, 0, 0};   tv[1]  = '{1, 1, 0};   tv[2]  = '{8, 2, 0};
    tv[3]  = '{16, 3, 0};  tv[4]  = '{9, 4, 0};   tv[5]  = '{2, 5, 0};
    tv[6]  = '{3, 6, 0};   tv[7]  = '{4, 14, 0};  tv[8]  = '{7, 28, 0};
    tv[9]  = '{56, 35, 0}; tv[10] = '{62, 62, 0}; tv[11] = '{63, 63, 1};
    for (int k = 0; k < 64; k++) rz[zz[k]] = k;

    // Reset values
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_addr", out_addr, 0);
    chk("reset_out_last", out_last, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Single block, data = zigzag index, with first-word latency
    base = log_q.size();
    send_words(63, 1, 0);
    push_word(DW'(63), 1'b0);
    chk("lat_edge_plus0", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge_plus1", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge_plus2_valid", out_valid, 1);
    chk("lat_edge_plus2_addr", out_addr, 0);
    wait_log("blk1_count", base + 64, 200);
    for (int v = 0; v < 12; v++) begin
      chk($sformatf("raster_addr%0d_data", tv[v].addr), log_q[base + tv[v].addr].d, tv[v].exp_d);
      chk($sformatf("raster_addr%0d_last", tv[v].addr), log_q[base + tv[v].addr].l, tv[v].exp_last);
    end
    check_blocks("blk1", base, 1, 1, 0);
    repeat (5) @(posedge clk);
    #1;

    // Three back-to-back blocks at full rate
    base = log_q.size();
    s0   = in_stall;
    send_words(192, 1, 0);
    chk("b2b_in_ready_drops", in_stall - s0, 0);
    wait_log("b2b_count", base + 192, 400);
    check_blocks("b2b", base, 3, 1, 0);

    // Output held off: both banks fill, then drain on release
    base = log_q.size();
    a0   = acc_cnt;
    out_ready = 1'b0;
    fork
      send_words(200, 1, 0);
      begin
        t = 0;
        while (acc_cnt - a0 < 128 && t < 1000) begin
          @(posedge clk);
          #1;
          t++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("stall_accepts", acc_cnt - a0, 128);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_addr", out_addr, 0);
        out_ready = 1'b1;
      end
    join
    wait_log("stall_count", base + 192, 400);
    check_blocks("stall", base, 3, 1, 0);

    // Random downstream backpressure
    do_reset();
    base = log_q.size();
    s0   = stab_err;
    fork
      send_words(128, 7, 3);
      begin
        t = 0;
        while (log_q.size() < base + 128 && t < 4000) begin
          out_ready = ($urandom_range(0, 1) != 0);
          @(posedge clk);
          #1;
          t++;
        end
        out_ready = 1'b1;
      end
    join
    wait_log("rand_count", base + 128, 400);
    check_blocks("rand", base, 2, 7, 3);
    chk("rand_hold_errs", stab_err - s0, 0);

    // Reset in the middle of a block
    send_words(30, 1, 0);
    do_reset();
    base = log_q.size();
    repeat (80) @(posedge clk);
    #1;
    chk("midrst_no_output", log_q.size(), base);
    send_words(64, 1, 100);
    wait_log("midrst_count", base + 64, 200);
    check_blocks("midrst", base, 1, 1, 100);

`ifdef INV_ZIGZAG_EOB_EN
    // Early end-of-block: remaining positions zero-filled
    do_reset();
    base = log_q.size();
    push_word(DW'(5), 1'b0);
    push_word(10'h3FD, 1'b0);
    push_word(DW'(7), 1'b1);
    lo = 0;
    t  = 0;
    while (t < 200) begin
      @(negedge clk);
      if (in_ready) break;
      lo++;
      t++;
    end
    chk("eob_ready_low_cycles", lo, 61);
    wait_log("eob_count", base + 64, 300);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      ed = (i == 0) ? DW'(5) : (i == 1) ? 10'h3FD : (i == 8) ? DW'(7) : '0;
      if (base + i >= log_q.size() || log_q[base + i].d !== ed || log_q[base + i].a !== 6'(i)) errs++;
    end
    chk("eob_data_errs", errs, 0);
`endif

    repeat (5) @(posedge clk);
    chk("hold_errs_total", stab_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
